mul_div_controller: RTL and testbench
=====================================

# mul_div_controller

Iterative multiply/divide sequencer for the MIPS core, owning the HI/LO registers. The pipeline issues MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO to it. It runs a 32-iteration shift-add or restoring-divide datapath over multiple cycles, and stalls the pipeline while an operation is in flight. It sits beside the ALU in the datapath and is driven from the main decoder.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low clears all state.
- start  in  1  issue request; held by the pipeline until accepted.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- rd_req  in  1  MFHI/MFLO in decode needs HI or LO this cycle.
- hi_wr, lo_wr  in  1 each  MTHI / MTLO write enables.
- wdata  in  WIDTH  MTHI/MTLO data.
- hi, lo  out  WIDTH  architectural HI/LO contents.
- busy  out  1  operation in flight.
- stall  out  1  pipeline hold = busy & (start | rd_req | hi_wr | lo_wr).

## Operation
- States: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 at a clock edge: capture |a|, |b| (signed ops) or a, b (unsigned ops), op, and operand signs; count<=0; go to RUN.
  - start=0: no state change.
- RUN: one iteration per cycle; count increments; after iteration WIDTH-1 go to FIXUP.
  - Multiply: 2*WIDTH-bit accumulator; add multiplicand if multiplier LSB=1, shift right.
  - Divide: restoring; shift remainder:quotient left, trial-subtract divisor, keep if non-negative, set quotient bit.
- FIXUP: apply sign correction, write hi/lo, go to IDLE.
  - MULT: negate the 64-bit product if signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
- Result mapping:
  - Multiply: hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Divide: lo = quotient, hi = remainder.
- Arithmetic is modulo 2^WIDTH per half; no exceptions.
- Divide by zero (any signedness): lo = all ones, hi = a. Same latency.
- DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps).
- MTHI/MTLO: in IDLE, wdata is written on the edge.
  - While busy they are not performed; stall holds them.
  - hi_wr together with start in IDLE: the start wins, and the write is held off by stall once busy.
- start while busy: not accepted; stall asserted, pipeline retries.
- rd_req in IDLE: no stall; hi/lo are already final.
- Asynchronous reset (any state, including mid-RUN): state=IDLE, hi=0, lo=0, count=0, busy=0, stall=0. The in-flight operation is discarded.

## Timing
- Reset values: hi=0, lo=0, busy=0, stall=0 (stall is combinational, so 0 whenever busy=0).
- The accepting edge is E0.
- busy=1 from after E0 until after E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- hi/lo update at E(WIDTH+1) and are readable in the following cycle.
- No forwarding of partial results. hi/lo hold their old value throughout RUN.
- Back-to-back: a new start may be accepted on the first edge where busy=0 (E(WIDTH+2)).
- stall is purely combinational from busy and the request inputs; no extra registered cycle.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - state encoding (IDLE, RUN, FIXUP);
  - count width, clog2(WIDTH).
- One combinational sub-module, mul_div_step: performs a single multiply or divide iteration on {acc_hi, acc_lo, operand} and returns the next accumulator.
- The controller holds the FSM, counter, sign flags, HI/LO registers and stall logic.

## Test plan
- MULTU 0xFFFFFFFF * 0xFFFFFFFF: after 33 busy cycles, hi=0xFFFFFFFE, lo=0x00000001; busy low on the next cycle.
- MULT -3 * 7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall rules:
  - rd_req held from cycle 5 of a DIVU: stall=1 until busy falls, with the same-cycle combinational release.
  - MTLO 0x1234 issued mid-operation: not applied until IDLE; then lo=0x1234.
- Reset pulled low at RUN count 10 of a MULTU: busy, stall, hi and lo all 0 immediately. After release, a fresh MULTU 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and sizing for the multiply/divide sequencer
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int CNT_W = $clog2(MD_WIDTH);
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_e;
endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one shift-add multiply or restoring-divide iteration on {acc_hi, acc_lo}
module mul_div_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);
  logic [WIDTH:0] sum, rs;
  logic [WIDTH-1:0] diff;
  logic ge;
  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rs = {acc_hi, acc_lo[WIDTH-1]};
    ge = rs >= {1'b0, operand};
    // remainder stays below the divisor, so the low WIDTH bits of the difference are exact
    diff = rs[WIDTH-1:0] - operand;
    nxt_hi = div ? (ge ? diff : rs[WIDTH-1:0]) : sum[WIDTH:1];
    nxt_lo = div ? {acc_lo[WIDTH-2:0], ge} : {sum[0], acc_lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul_div_controller.sv
// mul_div_controller: iterative MULT/DIV sequencer owning HI/LO, with pipeline stall generation
module mul_div_controller
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);
  state_e state, nxt;
  logic [$clog2(WIDTH)-1:0] count;
  logic div, sa, sb, bz, last;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand, step_hi, step_lo, abs_a, abs_b, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;
  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .div(div), .acc_hi(acc_hi), .acc_lo(acc_lo), .operand(operand),
    .nxt_hi(step_hi), .nxt_lo(step_lo)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    last = count == ($clog2(WIDTH))'(WIDTH - 1);
    nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? FIXUP : RUN) : IDLE;
    busy = state != IDLE;
    stall = busy & (start | rd_req | hi_wr | lo_wr);
    abs_a = op[0] && a[WIDTH-1] ? -a : a;
    abs_b = op[0] && b[WIDTH-1] ? -b : b;
    prod = sa ^ sb ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    // divide-by-zero leaves the dividend in the remainder; only the quotient needs forcing
    fix_hi = div ? (sa ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
    fix_lo = div ? (bz ? '1 : sa ^ sb ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hi <= '0;
      lo <= '0;
      count <= '0;
      div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      operand <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        div <= op[1];
        sa <= op[0] & a[WIDTH-1];
        sb <= op[0] & b[WIDTH-1];
        bz <= b == '0;
        count <= '0;
        acc_hi <= '0;
        acc_lo <= op[1] ? abs_a : abs_b;
        operand <= op[1] ? abs_b : abs_a;
      end else begin
        if (hi_wr) hi <= wdata;
        if (lo_wr) lo <= wdata;
      end
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      count <= count + 1'b1;
    end else begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
endmodule

// File: tb/tb_mul_div_controller.sv
// tb_mul_div_controller: random and directed MULT/DIV checks against a plain-arithmetic HI/LO model
module tb_mul_div_controller;
  logic clk = 0, reset = 0, start = 0, rd_req = 0, hi_wr = 0, lo_wr = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0, hi, lo, mhi = 0, mlo = 0;
  logic busy, stall;
  int vectors = 0, miscompares = 0;
  mul_div_controller dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd_req(rd_req),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o == 2'd0) return {32'b0, x} * {32'b0, y};
    if (o == 2'd1) return 64'(sx * sy);
    if (y == 0) return {x, 32'hffffffff};
    if (o == 2'd2) return {x % y, x / y};
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {r[31:0], q[31:0]};
  endfunction
  // rd: 0 none, 1 random each cycle, 2 held from cycle 5; wr_at: cycle at which MTLO 0x1234 is raised (-1 none)
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int rd, input int wr_at);
    logic [63:0] e;
    e = model(o, x, y);
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 33; i++) begin
      rd_req = rd == 1 ? 1'($urandom % 2) : rd == 2 ? i >= 5 : 1'b0;
      if (i == wr_at) begin lo_wr = 1; wdata = 32'h1234; end
      #1;
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("stall_run", {31'b0, stall}, {31'b0, rd_req | lo_wr});
      if (i == 0 || i == 32) begin
        chk("hi_hold", hi, mhi);
        chk("lo_hold", lo, mlo);
      end
      @(posedge clk); #1;
    end
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("stall_release", {31'b0, stall}, 32'd0);
    chk("hi_result", hi, e[63:32]);
    chk("lo_result", lo, e[31:0]);
    mhi = e[63:32];
    mlo = e[31:0];
    rd_req = 0;
    if (lo_wr) begin
      @(posedge clk); #1;
      lo_wr = 0;
      mlo = 32'h1234;
      chk("mtlo_after", lo, mlo);
    end
  endtask
  initial begin
    logic [31:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    reset = 1;
    @(posedge clk); #1;
    run_op(2'd0, 32'hffffffff, 32'hffffffff, 0, -1);
    run_op(2'd1, 32'hfffffffd, 32'h7, 1, -1);
    run_op(2'd3, 32'hfffffff9, 32'h2, 0, -1);
    run_op(2'd2, 32'd100, 32'd0, 1, -1);
    run_op(2'd3, 32'h80000000, 32'hffffffff, 0, -1);
    run_op(2'd3, 32'hfffffff9, 32'h0, 0, -1);
    run_op(2'd2, $urandom, $urandom, 2, -1);
    run_op(2'd2, $urandom, $urandom_range(1, 1000), 0, 5);
    hi_wr = 1; wdata = 32'h5a5a5a5a;
    @(posedge clk); #1;
    mhi = 32'h5a5a5a5a;
    chk("mthi_idle", hi, mhi);
    wdata = 32'hdeadbeef;
    op = 2'd0; a = 32'd2; b = 32'd3; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_wins_hi", hi, mhi);
    chk("start_wins_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 40 && busy; i++) begin @(posedge clk); #1; end
    chk("held_mthi_busy", {31'b0, busy}, 32'd0);
    chk("held_mthi_lo", lo, 32'd6);
    @(posedge clk); #1;
    hi_wr = 0;
    mhi = 32'hdeadbeef;
    mlo = 32'd6;
    chk("held_mthi_hi", hi, mhi);
    for (int n = 0; n < 40; n++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: y = 32'hffffffff;
        2: x = 32'h80000000;
        3: y = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(2'($urandom), x, y, 1, -1);
    end
    op = 2'd0; a = 32'hffffffff; b = 32'hffffffff; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    rd_req = 1;
    #1;
    chk("pre_rst_stall", {31'b0, stall}, 32'd1);
    reset = 0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_stall", {31'b0, stall}, 0);
    chk("mid_rst_hi", hi, 0);
    chk("mid_rst_lo", lo, 0);
    rd_req = 0;
    mhi = 0;
    mlo = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    run_op(2'd0, 32'd6, 32'd7, 0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
